// File: rtl/led_axi_pkg.sv
// ============================================================================
// Module  : led_axi_pkg
// Purpose : Shared types and constants for the LED AXI4 burst slave.
//           LED_AXI_WRAP_BURST_EN selects WRAP burst support in the slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] c_size_word = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // A wrap window must be a power-of-two number of beats (2, 4, 8 or 16).
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_axi4_burst_slave_addr_gen.sv
// ============================================================================
// Module  : axi_burst_addr_gen
// Purpose : Combinational next word index and burst-legality flag.
//           WRAP is legal only when LED_AXI_WRAP_BURST_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
    import led_axi_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic [7:0]       i_len,
    input  logic [2:0]       i_size,
    input  logic [1:0]       i_burst,
    output logic [IDX_W-1:0] o_next_idx,
    output logic             o_err
);

`ifdef LED_AXI_WRAP_BURST_EN
    localparam bit c_wrap_en = 1'b1;
`else
    localparam bit c_wrap_en = 1'b0;
`endif

    logic [IDX_W-1:0] w_inc;
    logic [IDX_W-1:0] w_mask;
    logic             w_wrap_ok;

    assign w_inc     = i_idx + IDX_W'(1);
    assign w_mask    = IDX_W'(i_len);
    assign w_wrap_ok = c_wrap_en && wrap_len_ok(i_len);

    always_comb begin
        o_next_idx = i_idx;
        o_err      = (i_size != c_size_word);
        case (burst_t'(i_burst))
            FIXED: o_next_idx = i_idx;
            INCR:  o_next_idx = w_inc;
            WRAP: begin
                // Low bits step within the window, high bits stay on its aligned base.
                o_next_idx = (i_idx & ~w_mask) | (w_inc & w_mask);
                if (!w_wrap_ok) begin
                    o_err = 1'b1;
                end
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/led_axi4_burst_slave.sv
// ============================================================================
// Module  : led_axi4_burst_slave
// Purpose : AXI4 burst slave over a small register bank; word 0 drives the LEDs.
//           Define LED_AXI_WRAP_BURST_EN to accept WRAP bursts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_axi4_burst_slave
    import led_axi_pkg::*;
#(
    parameter int C_ID_WIDTH   = 1,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 6,
    parameter int C_MEM_WORDS  = 16,
    parameter int C_NUM_LEDS   = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                S_AXI_AWLEN,
    input  logic [2:0]                S_AXI_AWSIZE,
    input  logic [1:0]                S_AXI_AWBURST,
    input  logic                      S_AXI_AWLOCK,
    input  logic [3:0]                S_AXI_AWCACHE,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic [3:0]                S_AXI_AWQOS,
    input  logic [3:0]                S_AXI_AWREGION,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                      S_AXI_WLAST,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [C_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [C_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                S_AXI_ARLEN,
    input  logic [2:0]                S_AXI_ARSIZE,
    input  logic [1:0]                S_AXI_ARBURST,
    input  logic                      S_AXI_ARLOCK,
    input  logic [3:0]                S_AXI_ARCACHE,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic [3:0]                S_AXI_ARQOS,
    input  logic [3:0]                S_AXI_ARREGION,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [C_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RLAST,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [C_NUM_LEDS-1:0]     led_o
);

    localparam int c_idx_w  = $clog2(C_MEM_WORDS);
    localparam int c_nbytes = C_DATA_WIDTH / 8;

    logic [C_DATA_WIDTH-1:0] r_mem [C_MEM_WORDS];
    logic [C_NUM_LEDS-1:0]   r_led;

    // ------------------------------------------------------------ write side
    wr_state_t               r_wr_state;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic [C_ID_WIDTH-1:0]   r_bid;
    logic [c_idx_w-1:0]      r_wr_idx;
    logic [7:0]              r_wr_len;
    logic [2:0]              r_wr_size;
    logic [1:0]              r_wr_burst;
    logic [7:0]              r_wr_cnt;
    logic                    r_wr_over;

    logic [c_idx_w-1:0]      w_wr_next_idx;
    logic                    w_wr_cfg_err;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_wr_en;
    logic [C_DATA_WIDTH-1:0] w_wr_word;

    assign w_aw_hs = S_AXI_AWVALID && r_awready;
    assign w_w_hs  = S_AXI_WVALID && r_wready;
    assign w_b_hs  = r_bvalid && S_AXI_BREADY;

    axi_burst_addr_gen #(
        .IDX_W (c_idx_w)
    ) u_wr_addr_gen (
        .i_idx      (r_wr_idx),
        .i_len      (r_wr_len),
        .i_size     (r_wr_size),
        .i_burst    (r_wr_burst),
        .o_next_idx (w_wr_next_idx),
        .o_err      (w_wr_cfg_err)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= '0;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_size  <= '0;
            r_wr_burst <= '0;
            r_wr_cnt   <= '0;
            r_wr_over  <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid      <= S_AXI_AWID;
                        r_wr_idx   <= S_AXI_AWADDR[2 +: c_idx_w];
                        r_wr_len   <= S_AXI_AWLEN;
                        r_wr_size  <= S_AXI_AWSIZE;
                        r_wr_burst <= S_AXI_AWBURST;
                        r_wr_cnt   <= '0;
                        r_wr_over  <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wr_state <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (S_AXI_WLAST) begin
                            r_wready   <= 1'b0;
                            r_bvalid   <= 1'b1;
                            r_bresp    <= (w_wr_cfg_err || r_wr_over || (r_wr_cnt != r_wr_len))
                                          ? RESP_SLVERR : RESP_OKAY;
                            r_wr_state <= W_RESP;
                        end else if (!r_wr_over) begin
                            // Final beat seen without WLAST: swallow the rest of the burst.
                            if (r_wr_cnt == r_wr_len) begin
                                r_wr_over <= 1'b1;
                            end else begin
                                r_wr_cnt <= r_wr_cnt + 8'd1;
                                r_wr_idx <= w_wr_next_idx;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_wr_word = r_mem[r_wr_idx];
        for (int b = 0; b < c_nbytes; b++) begin
            if (S_AXI_WSTRB[b]) begin
                w_wr_word[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign w_wr_en = w_w_hs && (r_wr_state == W_DATA) && !r_wr_over && !w_wr_cfg_err;

    // LEDs take the merged word on the same edge as the bank so they track word 0 exactly.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < C_MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_led <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_idx] <= w_wr_word;
            if (r_wr_idx == '0) begin
                r_led <= w_wr_word[C_NUM_LEDS-1:0];
            end
        end
    end

    // ------------------------------------------------------------- read side
    rd_state_t               r_rd_state;
    logic                    r_arready;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [1:0]              r_rresp;
    logic [C_ID_WIDTH-1:0]   r_rid;
    logic [C_DATA_WIDTH-1:0] r_rdata;
    logic [c_idx_w-1:0]      r_rd_idx;
    logic [7:0]              r_rd_len;
    logic [2:0]              r_rd_size;
    logic [1:0]              r_rd_burst;
    logic [7:0]              r_rd_cnt;

    logic [c_idx_w-1:0]      w_rd_gen_idx;
    logic [7:0]              w_rd_gen_len;
    logic [2:0]              w_rd_gen_size;
    logic [1:0]              w_rd_gen_burst;
    logic [c_idx_w-1:0]      w_rd_next_idx;
    logic                    w_rd_err;
    logic                    w_ar_hs;
    logic                    w_r_hs;

    assign w_ar_hs = S_AXI_ARVALID && r_arready;
    assign w_r_hs  = r_rvalid && S_AXI_RREADY;

    // While idle the generator judges the incoming AR request; afterwards the latched burst.
    always_comb begin
        if (r_rd_state == R_IDLE) begin
            w_rd_gen_idx   = S_AXI_ARADDR[2 +: c_idx_w];
            w_rd_gen_len   = S_AXI_ARLEN;
            w_rd_gen_size  = S_AXI_ARSIZE;
            w_rd_gen_burst = S_AXI_ARBURST;
        end else begin
            w_rd_gen_idx   = r_rd_idx;
            w_rd_gen_len   = r_rd_len;
            w_rd_gen_size  = r_rd_size;
            w_rd_gen_burst = r_rd_burst;
        end
    end

    axi_burst_addr_gen #(
        .IDX_W (c_idx_w)
    ) u_rd_addr_gen (
        .i_idx      (w_rd_gen_idx),
        .i_len      (w_rd_gen_len),
        .i_size     (w_rd_gen_size),
        .i_burst    (w_rd_gen_burst),
        .o_next_idx (w_rd_next_idx),
        .o_err      (w_rd_err)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_size  <= '0;
            r_rd_burst <= '0;
            r_rd_cnt   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid      <= S_AXI_ARID;
                        r_rd_idx   <= w_rd_gen_idx;
                        r_rd_len   <= S_AXI_ARLEN;
                        r_rd_size  <= S_AXI_ARSIZE;
                        r_rd_burst <= S_AXI_ARBURST;
                        r_rd_cnt   <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= (S_AXI_ARLEN == 8'd0);
                        r_rresp    <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_rdata    <= w_rd_err ? '0 : r_mem[w_rd_gen_idx];
                        r_rd_state <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_arready  <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 8'd1;
                            r_rd_idx <= w_rd_next_idx;
                            r_rlast  <= ((r_rd_cnt + 8'd1) == r_rd_len);
                            r_rdata  <= w_rd_err ? '0 : r_mem[w_rd_next_idx];
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rdata;
    assign led_o         = r_led;

    // Sideband and sub-word address bits carry no meaning for this bank.
    logic w_unused_sideband;
    assign w_unused_sideband = ^{S_AXI_AWADDR, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                                 S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_ARADDR, S_AXI_ARLOCK,
                                 S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION};

endmodule

`default_nettype wire

// File: tb/tb_led_axi4_burst_slave.sv
// ============================================================================
// Module  : tb_led_axi4_burst_slave
// Purpose : Directed bench for led_axi4_burst_slave; expectations follow
//           LED_AXI_WRAP_BURST_EN when it is defined for the build.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_axi4_burst_slave;
    import led_axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [5:0]  AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  led;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] wdat  [16];
    logic [31:0] exp_d [16];
    logic [1:0]  resp;
    logic [1:0]  exp_wrap_resp;
    logic [31:0] exp_w0, exp_w1, exp_w2, exp_w3;

    always #5 ACLK = ~ACLK;

    led_axi4_burst_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
        .S_AXI_AWBURST(AWBURST), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0),
        .S_AXI_AWQOS(4'h0), .S_AXI_AWREGION(4'h0), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
        .S_AXI_WREADY(WREADY), .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
        .S_AXI_BREADY(BREADY), .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
        .S_AXI_ARSIZE(ARSIZE), .S_AXI_ARBURST(ARBURST), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'h0),
        .S_AXI_ARPROT(3'h0), .S_AXI_ARQOS(4'h0), .S_AXI_ARREGION(4'h0), .S_AXI_ARVALID(ARVALID),
        .S_AXI_ARREADY(ARREADY), .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
        .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY), .led_o(led)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb, input int nbeats,
                            input int last_at, input bit get_resp, output logic [1:0] r);
        int n;
        r = 2'b11;
        @(negedge ACLK);
        AWID = 1'b1; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check("aw_timeout", 0, 1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            WDATA = wdat[i]; WSTRB = strb; WLAST = (i == last_at); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) check("w_timeout", 0, 1);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (get_resp) begin
            BREADY = 1'b1;
            n = 0;
            while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) check("b_timeout", 0, 1);
            r = BRESP;
            check("bid", BID, 1);
            @(negedge ACLK);
            BREADY = 1'b0;
        end
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [1:0] exp_resp, input int stall,
                           input string tag);
        int n;
        @(negedge ACLK);
        ARID = 1'b1; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARVALID = 1'b1;
        RREADY = (stall == 0);
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check({tag, "_ar_timeout"}, 0, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) check($sformatf("%s_r%0d_timeout", tag, i), 0, 1);
            if (i == 0) begin
                check({tag, "_rid"}, RID, 1);
                for (int k = 0; k < stall; k++) begin
                    check($sformatf("%s_stall%0d_valid", tag, k), RVALID, 1);
                    check($sformatf("%s_stall%0d_data", tag, k), RDATA, exp_d[0]);
                    @(negedge ACLK);
                end
            end
            RREADY = 1'b1;
            check($sformatf("%s_d%0d", tag, i), RDATA, exp_d[i]);
            check($sformatf("%s_last%0d", tag, i), RLAST, (i == int'(len)));
            check($sformatf("%s_resp%0d", tag, i), RRESP, exp_resp);
            @(negedge ACLK);
        end
        RREADY = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = INCR; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = INCR; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset state
        check("rst_awready", AWREADY, 0);
        check("rst_wready",  WREADY,  0);
        check("rst_bvalid",  BVALID,  0);
        check("rst_arready", ARREADY, 0);
        check("rst_rvalid",  RVALID,  0);
        check("rst_rlast",   RLAST,   0);
        check("rst_bresp",   BRESP,   RESP_OKAY);
        check("rst_rresp",   RRESP,   RESP_OKAY);
        check("rst_led",     led,     0);
        ARESET = 1'b0;

        // 1: INCR 8-beat write and read back
        for (int i = 0; i < 8; i++) begin wdat[i] = 32'(i + 1); exp_d[i] = 32'(i + 1); end
        do_write(6'h00, 8'd7, INCR, 3'd2, 4'hF, 8, 7, 1'b1, resp);
        check("t1_bresp", resp, RESP_OKAY);
        check("t1_led", led, 4'h1);
        do_read(6'h00, 8'd7, INCR, 3'd2, RESP_OKAY, 0, "t1");

        // 2: byte strobes
        wdat[0] = 32'h11223344;
        do_write(6'h04, 8'd0, INCR, 3'd2, 4'hF, 1, 0, 1'b1, resp);
        check("t2_bresp_a", resp, RESP_OKAY);
        wdat[0] = 32'hAABBCCDD;
        do_write(6'h04, 8'd0, INCR, 3'd2, 4'b0101, 1, 0, 1'b1, resp);
        check("t2_bresp_b", resp, RESP_OKAY);
        exp_d[0] = 32'h11BB33DD;
        do_read(6'h04, 8'd0, INCR, 3'd2, RESP_OKAY, 0, "t2");

        // 3: FIXED write lands every beat on word 2
        wdat[0] = 32'd5; wdat[1] = 32'd6; wdat[2] = 32'd7; wdat[3] = 32'd8;
        do_write(6'h08, 8'd3, FIXED, 3'd2, 4'hF, 4, 3, 1'b1, resp);
        check("t3_bresp", resp, RESP_OKAY);
        exp_d[0] = 32'd8; exp_d[1] = 32'd4; exp_d[2] = 32'd5; exp_d[3] = 32'd6;
        do_read(6'h08, 8'd3, INCR, 3'd2, RESP_OKAY, 0, "t3");

        // 4: WRAP write at word 2, LEN=3
`ifdef LED_AXI_WRAP_BURST_EN
        exp_wrap_resp = RESP_OKAY;
        exp_w0 = 32'hA2; exp_w1 = 32'hA3; exp_w2 = 32'hA0; exp_w3 = 32'hA1;
`else
        exp_wrap_resp = RESP_SLVERR;
        exp_w0 = 32'd1; exp_w1 = 32'h11BB33DD; exp_w2 = 32'd8; exp_w3 = 32'd4;
`endif
        wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
        do_write(6'h08, 8'd3, WRAP, 3'd2, 4'hF, 4, 3, 1'b1, resp);
        check("t4_bresp", resp, exp_wrap_resp);
        check("t4_led", led, exp_w0[3:0]);
        // WRAP with a non power-of-two length is always rejected
        wdat[0] = 32'hE0; wdat[1] = 32'hE1; wdat[2] = 32'hE2;
        do_write(6'h08, 8'd2, WRAP, 3'd2, 4'hF, 3, 2, 1'b1, resp);
        check("t4_badlen_bresp", resp, RESP_SLVERR);
        exp_d[0] = exp_w0; exp_d[1] = exp_w1; exp_d[2] = exp_w2; exp_d[3] = exp_w3;
        do_read(6'h00, 8'd3, INCR, 3'd2, RESP_OKAY, 0, "t4_incr");
`ifdef LED_AXI_WRAP_BURST_EN
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
`else
        for (int i = 0; i < 4; i++) exp_d[i] = 32'd0;
`endif
        do_read(6'h08, 8'd3, WRAP, 3'd2, exp_wrap_resp, 0, "t4_wrap");
        exp_d[0] = 32'd0; exp_d[1] = 32'd0;
        do_read(6'h00, 8'd1, RSVD, 3'd2, RESP_SLVERR, 0, "t4_rsvd");
        // Narrow-size write is consumed without touching memory
        wdat[0] = 32'h0000DEAD;
        do_write(6'h14, 8'd0, INCR, 3'd1, 4'hF, 1, 0, 1'b1, resp);
        check("t4_size_bresp", resp, RESP_SLVERR);
        exp_d[0] = 32'd6;
        do_read(6'h14, 8'd0, INCR, 3'd2, RESP_OKAY, 0, "t4_size");

        // 5: early WLAST, then a stalled read
        wdat[0] = 32'h100; wdat[1] = 32'h101; wdat[2] = 32'h102;
        do_write(6'h30, 8'd3, INCR, 3'd2, 4'hF, 3, 2, 1'b1, resp);
        check("t5_bresp", resp, RESP_SLVERR);
        exp_d[0] = exp_w0; exp_d[1] = exp_w1;
        do_read(6'h00, 8'd1, INCR, 3'd2, RESP_OKAY, 5, "t5_stall");
        // Missing WLAST: the extra beat must not be written; INCR read wraps 15 -> 0
        wdat[0] = 32'h55; wdat[1] = 32'h66;
        do_write(6'h3C, 8'd0, INCR, 3'd2, 4'hF, 2, 1, 1'b1, resp);
        check("t5_over_bresp", resp, RESP_SLVERR);
        exp_d[0] = 32'h55; exp_d[1] = exp_w0;
        do_read(6'h3C, 8'd1, INCR, 3'd2, RESP_OKAY, 0, "t5_mod");

        // 6: reset in the middle of an 8-beat write
        for (int i = 0; i < 8; i++) wdat[i] = 32'h11 + 32'(i);
        do_write(6'h00, 8'd7, INCR, 3'd2, 4'hF, 4, -1, 1'b0, resp);
        check("t6_led_pre", led, 4'h1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t6_awready", AWREADY, 0);
        check("t6_wready",  WREADY,  0);
        check("t6_bvalid",  BVALID,  0);
        check("t6_arready", ARREADY, 0);
        check("t6_rvalid",  RVALID,  0);
        check("t6_led",     led,     0);
        ARESET = 1'b0;
        for (int i = 0; i < 16; i++) exp_d[i] = 32'd0;
        do_read(6'h00, 8'd15, INCR, 3'd2, RESP_OKAY, 0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
